neuron_mac_unit: RTL and testbench
==================================

// Module: neuron_mac_unit
// PURPOSE
//  Sequential multiply-accumulate engine for one ANN neuron; sits directly downstream of the per-neuron weight BRAM.
//  On START it walks addresses 0..N_INPUTS-1, reads weight and input activation each cycle, and accumulates signed products.
//  It then adds BIAS, applies the optional activation, saturates to DATA_W and presents the result on a valid/ready port.
// PARAMETERS
//  N_INPUTS   28  number of weight/input pairs per neuron (BRAM depth)
//  ADDR_W     5   address width, ceil(log2(N_INPUTS))
//  DATA_W     16  signed two's-complement fixed-point word (weights, inputs, bias, output)
//  FRAC_BITS  8   fractional bits of the Q format (1.0 = 0x0100)
//  ACC_W      40  accumulator width; no wrap for N_INPUTS <= 256
// PORTS
//  CLK        in   1       system clock, rising-edge logic; the BRAMs read on the falling edge
//  RST        in   1       asynchronous, active-high reset
//  START      in   1       start pulse; sampled only in IDLE
//  BIAS       in   DATA_W  neuron bias, Q format; must be stable from START until OUT_VALID
//  W_ADDR     out  ADDR_W  address to weight BRAM
//  W_EN       out  1       weight BRAM enable
//  W_WE       out  1       weight BRAM write enable; tied 0
//  W_DO       in   DATA_W  weight read data
//  X_ADDR     out  ADDR_W  address to input-activation buffer; always equals W_ADDR
//  X_EN       out  1       input buffer enable; always equals W_EN
//  X_DO       in   DATA_W  input read data; same negedge-read timing as W_DO
//  BUSY       out  1       high from the cycle after START acceptance until the output handshake completes
//  OUT_DATA   out  DATA_W  neuron result
//  OUT_VALID  out  1       result valid
//  OUT_READY  in   1       consumer ready
// BEHAVIOUR
//  Reset: state=IDLE; W_ADDR=0, W_EN=0, W_WE=0, BUSY=0, OUT_VALID=0, OUT_DATA=0, accumulator=0. Applies at any time, including mid-operation.
//  States: IDLE -> ISSUE -> DRAIN -> BIAS -> ACT -> DONE -> IDLE.
//  IDLE:  on START=1, clear the accumulator, set W_ADDR=0 and W_EN=1, then go to ISSUE.
//  ISSUE: increment W_ADDR by one per cycle. The data for address k is captured on the posedge after it is issued and
//         its product is accumulated. After address N_INPUTS-1 is issued, W_EN falls and the FSM goes to DRAIN.
//         W_ADDR never reaches N_INPUTS; on exit it returns to 0.
//  DRAIN: accumulate the last product.
//  BIAS:  acc <= acc + sign_extend(BIAS) << FRAC_BITS.
//  ACT:   shift acc right arithmetically by FRAC_BITS (truncate toward -inf); apply activation; saturate to
//         [-2^(DATA_W-1), 2^(DATA_W-1)-1]; register into OUT_DATA.
//  DONE:  OUT_VALID=1 and OUT_DATA held stable until OUT_READY=1; on the handshake cycle, go to IDLE with OUT_VALID=0 and BUSY=0.
//  Latency: OUT_VALID rises exactly N_INPUTS+4 rising edges after the edge that samples START (32 for N_INPUTS=28).
//  Products: full 2*DATA_W signed product, sign-extended to ACC_W; no intermediate rounding.
//  START while BUSY, or in the handshake cycle itself, is ignored; no queuing.
//  OUT_READY=1 before OUT_VALID=1 has no effect.
// CONFIGURATION
//  NEURON_RELU_EN defined:     ACT clamps negative results to 0 (ReLU) before saturation.
//  NEURON_RELU_EN not defined: linear activation; the signed result is saturated only.
// STRUCTURE
//  ann_pkg: DATA_W, FRAC_BITS, ACC_W, state encodings (localparams), Q-format constant ONE=0x0100.
//  Sub-module ann_sat_act: combinational shift, activation and saturation (ACC_W in, DATA_W out); it holds the
//  NEURON_RELU_EN switch. The top holds the FSM, the address counter and the accumulator.
// TESTING
//  1. All W=0x0100, X=0x0100, BIAS=0, START -> OUT_DATA=0x1C00 (28.0), OUT_VALID at edge 32, W_WE always 0.
//  2. All W=0xFF00 (-1.0), X=0x0100, BIAS=0 -> OUT_DATA=0x0000 with NEURON_RELU_EN; 0xE400 (-28.0) without.
//  3. All W=0x7FFF, X=0x7FFF -> OUT_DATA=0x7FFF (positive saturation); W=0x8000, X=0x7FFF, no ReLU -> 0x8000.
//  4. All W=0, BIAS=0x0380 -> OUT_DATA=0x0380; W_ADDR sequence is 0..27, each address once, W_EN high for exactly 28 cycles.
//  5. OUT_READY held low for 5 cycles after OUT_VALID, START pulsed meanwhile -> OUT_DATA/OUT_VALID stable, no restart,
//     IDLE one cycle after READY.
//  6. RST asserted on edge 10 of a run -> BUSY=0, W_EN=0, OUT_VALID=0 immediately; next START gives the correct result of test 1.

Source files
------------

// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared widths, FSM states and Q-format constants for the neuron MAC
package ann_pkg;

    localparam int N_INPUTS  = 28;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 40;

    localparam logic [DATA_W-1:0] ONE = 16'h0100;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_BIAS  = 3'd3,
        S_ACT   = 3'd4,
        S_DONE  = 3'd5
    } mac_state_t;

endpackage

// File: rtl/ann_sat_act.sv
// rtl/ann_sat_act.sv - Q-format rescale, activation and saturation; NEURON_RELU_EN selects ReLU
module ann_sat_act
    import ann_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc,
    output logic        [DATA_W-1:0] result
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;

    // Drop the fractional product bits (floor), apply activation, clip into the output word
    always_comb begin
        shifted = acc >>> FRAC_BITS;
`ifdef NEURON_RELU_EN
        if (shifted[ACC_W-1]) begin
            shifted = '0;
        end
`endif
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[DATA_W-1:0];
        end else begin
            result = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/neuron_mac_unit.sv
// rtl/neuron_mac_unit.sv - sequential MAC neuron over weight/input BRAMs; NEURON_RELU_EN enables ReLU
module neuron_mac_unit
    import ann_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [DATA_W-1:0] BIAS,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic              W_EN,
    output logic              W_WE,
    input  logic [DATA_W-1:0] W_DO,
    output logic [ADDR_W-1:0] X_ADDR,
    output logic              X_EN,
    input  logic [DATA_W-1:0] X_DO,
    output logic              BUSY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);

    mac_state_t state, state_nxt;

    logic [ADDR_W-1:0]         addr;
    logic                      en;
    logic signed [2*DATA_W-1:0] prod_q;
    logic [ACC_W-1:0]          acc;
    logic [DATA_W-1:0]         out_data_q;
    logic                      out_valid_q;
    logic [DATA_W-1:0]         act_result;
    logic                      last_addr;
    logic signed [2*DATA_W-1:0] w_ext, x_ext;
    logic [ACC_W-1:0]          prod_ext, bias_ext;

    assign last_addr = (addr == ADDR_W'(N_INPUTS - 1));
    assign w_ext     = {{DATA_W{W_DO[DATA_W-1]}}, W_DO};
    assign x_ext     = {{DATA_W{X_DO[DATA_W-1]}}, X_DO};
    assign prod_ext  = {{(ACC_W-2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q};
    assign bias_ext  = {{(ACC_W-DATA_W-FRAC_BITS){BIAS[DATA_W-1]}}, BIAS, {FRAC_BITS{1'b0}}};

    ann_sat_act u_sat_act (
        .acc    (acc),
        .result (act_result)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; DONE leaves only on a completed handshake
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = S_ISSUE;
            S_ISSUE: if (last_addr) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_BIAS;
            S_BIAS:  state_nxt = S_ACT;
            S_ACT:   state_nxt = S_DONE;
            S_DONE:  if (out_valid_q && OUT_READY) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address walk, product pipeline (one stage behind capture), accumulator and result register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr        <= '0;
            en          <= 1'b0;
            prod_q      <= '0;
            acc         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        acc    <= '0;
                        prod_q <= '0;
                        addr   <= '0;
                        en     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    prod_q <= w_ext * x_ext;
                    acc    <= acc + prod_ext;
                    if (last_addr) begin
                        en   <= 1'b0;
                        addr <= '0;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                S_DRAIN: acc <= acc + prod_ext;
                S_BIAS:  acc <= acc + bias_ext;
                S_ACT:   out_data_q <= act_result;
                S_DONE: begin
                    // One settle cycle with the result already registered before VALID is raised
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign W_ADDR    = addr;
    assign W_EN      = en;
    assign W_WE      = 1'b0;
    assign X_ADDR    = addr;
    assign X_EN      = en;
    assign BUSY      = (state != S_IDLE);
    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// tb/tb_neuron_mac_unit.sv - directed-vector bench for neuron_mac_unit
module tb_neuron_mac_unit;
    import ann_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [DATA_W-1:0] bias = '0;
    logic [ADDR_W-1:0] w_addr, x_addr;
    logic              w_en, w_we, x_en;
    logic [DATA_W-1:0] w_do = '0, x_do = '0;
    logic              busy;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] w_mem [N_INPUTS];
    logic [DATA_W-1:0] x_mem [N_INPUTS];

    int   en_cycles = 0;
    int   we_err = 0;
    int   mirror_err = 0;
    logic [ADDR_W-1:0] addr_log [$];

    neuron_mac_unit dut (
        .CLK       (clk),
        .RST       (rst),
        .START     (start),
        .BIAS      (bias),
        .W_ADDR    (w_addr),
        .W_EN      (w_en),
        .W_WE      (w_we),
        .W_DO      (w_do),
        .X_ADDR    (x_addr),
        .X_EN      (x_en),
        .X_DO      (x_do),
        .BUSY      (busy),
        .OUT_DATA  (out_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready)
    );

    always #5 clk = ~clk;

    // BRAM models read on the falling edge
    always @(negedge clk) begin
        if (w_en && w_addr < ADDR_W'(N_INPUTS)) w_do <= w_mem[w_addr];
        if (x_en && x_addr < ADDR_W'(N_INPUTS)) x_do <= x_mem[x_addr];
    end

    // Port monitor
    always @(negedge clk) begin
        if (w_en) begin
            en_cycles = en_cycles + 1;
            addr_log.push_back(w_addr);
        end
        if (w_we !== 1'b0) we_err = we_err + 1;
        if (x_addr !== w_addr || x_en !== w_en) mirror_err = mirror_err + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_mem(input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] x);
        for (int i = 0; i < N_INPUTS; i++) begin
            w_mem[i] = w;
            x_mem[i] = x;
        end
    endtask

    task automatic run_neuron(input logic [DATA_W-1:0] b, output int lat, output logic [DATA_W-1:0] res);
        @(negedge clk);
        bias  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat = lat + 1;
        end
        res = out_data;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic vec(input string tag, input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] x,
                       input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] exp);
        int lat;
        logic [DATA_W-1:0] res;
        load_mem(w, x);
        run_neuron(b, lat, res);
        check_eq({tag, "_data"}, 32'(res), 32'(exp));
        check_eq({tag, "_latency"}, 32'(lat), 32'(N_INPUTS + 4));
        check_eq({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int seq_err;
        logic [DATA_W-1:0] held;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_w_en", 32'(w_en), 32'd0);
        check_eq("rst_w_addr", 32'(w_addr), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        vec("ones", 16'h0100, 16'h0100, 16'h0000, 16'h1C00);
`ifdef NEURON_RELU_EN
        vec("neg_ones", 16'hFF00, 16'h0100, 16'h0000, 16'h0000);
        vec("neg_sat", 16'h8000, 16'h7FFF, 16'h0000, 16'h0000);
`else
        vec("neg_ones", 16'hFF00, 16'h0100, 16'h0000, 16'hE400);
        vec("neg_sat", 16'h8000, 16'h7FFF, 16'h0000, 16'h8000);
`endif
        vec("pos_sat", 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF);
        vec("half_two_bias", 16'h0080, 16'h0200, 16'hFF00, 16'h1B00);
`ifdef NEURON_RELU_EN
        vec("floor_neg", 16'hFFFF, 16'h0100, 16'h0000, 16'h0000);
`else
        vec("floor_neg", 16'hFFFF, 16'h0100, 16'h0000, 16'hFFE4);
`endif

        // Bias only, with address sequence and enable length
        en_cycles = 0;
        addr_log.delete();
        vec("bias_only", 16'h0000, 16'h0100, 16'h0380, 16'h0380);
        check_eq("en_cycles", 32'(en_cycles), 32'(N_INPUTS));
        check_eq("addr_count", 32'(addr_log.size()), 32'(N_INPUTS));
        seq_err = 0;
        for (int i = 0; i < addr_log.size(); i++) begin
            if (addr_log[i] !== ADDR_W'(i)) seq_err = seq_err + 1;
        end
        check_eq("addr_seq", 32'(seq_err), 32'd0);

        // Back-pressure: result held while stalled, START ignored, IDLE right after handshake
        load_mem(16'h0100, 16'h0100);
        @(negedge clk);
        bias  = 16'h0000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat = lat + 1;
        end
        check_eq("stall_latency", 32'(lat), 32'(N_INPUTS + 4));
        held = out_data;
        check_eq("stall_first_data", 32'(held), 32'h1C00);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start = (c == 2);
            @(posedge clk);
            #1;
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_data", 32'(out_data), 32'(held));
        end
        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        out_ready = 1'b0;
        check_eq("hs_valid_clr", 32'(out_valid), 32'd0);
        check_eq("hs_busy_clr", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("no_restart_busy", 32'(busy), 32'd0);
        check_eq("no_restart_en", 32'(w_en), 32'd0);

        // Reset mid-run
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_en", 32'(w_en), 32'd0);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        vec("after_rst", 16'h0100, 16'h0100, 16'h0000, 16'h1C00);

        check_eq("we_never", 32'(we_err), 32'd0);
        check_eq("x_mirrors_w", 32'(mirror_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
